// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EXE results and LSU load completions onto the single
// register-file write port, queueing loads in a small FIFO. Optional WB_PERF_CNT_EN adds perf counters.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exe_valid,
  output logic            exe_ready,
  input  logic [4:0]      exe_rd,
  input  logic            exe_rd_en,
  input  logic [XLEN-1:0] exe_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic            lsu_rd_en,
  input  logic [XLEN-1:0] lsu_data,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]     perf_wb_cnt,
  output logic [31:0]     perf_stall_cnt,
`endif
  output logic [4:0]      rd_final_rd_wb,
  output logic            rd_final_rd_wb_en,
  output logic [XLEN-1:0] rd_final_rd_wb_data
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic            full, lsu_xfer, lsu_real, waw;
  logic            push, pop, bypass;
  logic            sel_we;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [AW-1:0]   idx;

  assign full      = (count == (AW+1)'(DEPTH));
  assign lsu_ready = !full;
  assign lsu_xfer  = lsu_valid && lsu_ready;
  assign lsu_real  = lsu_xfer && lsu_rd_en && (lsu_rd != 5'd0);

  // Only occupied slots (head .. head+count-1) take part in the hazard compare.
  always_comb begin
    waw = lsu_xfer && (lsu_rd != 5'd0) && (lsu_rd == exe_rd);
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (((AW+1)'(i) < count) && (q_rd[idx] == exe_rd))
        waw = 1'b1;
    end
  end

  always_comb begin
    exe_ready = 1'b0;
    pop       = 1'b0;
    bypass    = 1'b0;
    sel_we    = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (full) begin
      pop = 1'b1;
    end else if (exe_valid && !waw) begin
      exe_ready = 1'b1;
      sel_we    = exe_rd_en && (exe_rd != 5'd0);
      sel_rd    = exe_rd;
      sel_data  = exe_data;
    end else if (count != '0) begin
      pop = 1'b1;
    end else if (lsu_real) begin
      bypass   = 1'b1;
      sel_we   = 1'b1;
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end
    if (pop) begin
      sel_we   = 1'b1;
      sel_rd   = q_rd[rd_ptr];
      sel_data = q_data[rd_ptr];
    end
  end

  assign push = lsu_real && !bypass;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_rd[wr_ptr]   <= lsu_rd;
        q_data[wr_ptr] <= lsu_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_final_rd_wb_en   <= 1'b0;
      rd_final_rd_wb      <= '0;
      rd_final_rd_wb_data <= '0;
    end else begin
      rd_final_rd_wb_en <= sel_we;
      if (sel_we) begin
        rd_final_rd_wb      <= sel_rd;
        rd_final_rd_wb_data <= sel_data;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_wb_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (rd_final_rd_wb_en && (perf_wb_cnt != '1))
        perf_wb_cnt <= perf_wb_cnt + 1'b1;
      if (exe_valid && !exe_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (DEPTH=2, XLEN=32) with hand-computed expectations.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exe_valid = 1'b0, exe_rd_en = 1'b0, exe_ready;
  logic [4:0]  exe_rd = '0;
  logic [31:0] exe_data = '0;
  logic        lsu_valid = 1'b0, lsu_rd_en = 1'b0, lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [4:0]  rd_final_rd_wb;
  logic        rd_final_rd_wb_en;
  logic [31:0] rd_final_rd_wb_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_wb_cnt, perf_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_rd(exe_rd),
    .exe_rd_en(exe_rd_en), .exe_data(exe_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_rd_en(lsu_rd_en), .lsu_data(lsu_data),
`ifdef WB_PERF_CNT_EN
    .perf_wb_cnt(perf_wb_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .rd_final_rd_wb(rd_final_rd_wb), .rd_final_rd_wb_en(rd_final_rd_wb_en),
    .rd_final_rd_wb_data(rd_final_rd_wb_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_exe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    exe_valid = v; exe_rd = rd; exe_rd_en = v; exe_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_rd_en = v; lsu_data = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] d);
    check({tag, "_en"},   64'(rd_final_rd_wb_en), 64'd1);
    check({tag, "_rd"},   64'(rd_final_rd_wb), 64'(rd));
    check({tag, "_data"}, 64'(rd_final_rd_wb_data), 64'(d));
  endtask

  initial begin
    #12;
    check("rst_en",   64'(rd_final_rd_wb_en), 64'd0);
    check("rst_rd",   64'(rd_final_rd_wb), 64'd0);
    check("rst_data", 64'(rd_final_rd_wb_data), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    reset = 1'b1;
    step();

    // EXE only
    set_exe(1'b1, 5'd5, 32'h1234_5678);
    #1 check("exe_only_ready", 64'(exe_ready), 64'd1);
    step();
    set_exe(1'b0, 5'd0, 32'h0);
    check_wb("exe_only", 5'd5, 32'h1234_5678);
    step();
    check("exe_only_idle", 64'(rd_final_rd_wb_en), 64'd0);

    // LSU bypass
    set_lsu(1'b1, 5'd7, 32'hDEAD_BEEF);
    #1 check("byp_ready", 64'(lsu_ready), 64'd1);
    step();
    set_lsu(1'b0, 5'd0, 32'h0);
    check_wb("byp", 5'd7, 32'hDEAD_BEEF);
    check("byp_count", 64'(dut.count), 64'd0);

    // Conflict: EXE first, LSU queued then drained
    set_exe(1'b1, 5'd3, 32'd1);
    set_lsu(1'b1, 5'd4, 32'd2);
    #1 check("conf_exe_ready", 64'(exe_ready), 64'd1);
    step();
    set_exe(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    check_wb("conf_x3", 5'd3, 32'd1);
    check("conf_count", 64'(dut.count), 64'd1);
    step();
    check_wb("conf_x4", 5'd4, 32'd2);
    step();
    check("conf_idle", 64'(rd_final_rd_wb_en), 64'd0);

    // WAW: queue load x9, then EXE x9 must wait for it
    set_exe(1'b1, 5'd1, 32'h11);
    set_lsu(1'b1, 5'd9, 32'hAA);
    step();
    set_lsu(1'b0, 5'd0, 32'h0);
    check_wb("waw_x1", 5'd1, 32'h11);
    set_exe(1'b1, 5'd9, 32'hBB);
    #1 check("waw_stall", 64'(exe_ready), 64'd0);
    step();
    check_wb("waw_load", 5'd9, 32'hAA);
    check("waw_go", 64'(exe_ready), 64'd1);
    step();
    set_exe(1'b0, 5'd0, 32'h0);
    check_wb("waw_exe", 5'd9, 32'hBB);

    // Full / starvation with DEPTH=2
    set_exe(1'b1, 5'd1, 32'h2001);
    set_lsu(1'b1, 5'd10, 32'h100A);
    step();
    check_wb("full_x1", 5'd1, 32'h2001);
    set_exe(1'b1, 5'd2, 32'h2002);
    set_lsu(1'b1, 5'd11, 32'h100B);
    #1 check("full_b_exe_ready", 64'(exe_ready), 64'd1);
    step();
    check_wb("full_x2", 5'd2, 32'h2002);
    set_exe(1'b1, 5'd3, 32'h2003);
    set_lsu(1'b1, 5'd12, 32'h100C);
    #1 check("full_lsu_ready", 64'(lsu_ready), 64'd0);
    check("full_exe_ready", 64'(exe_ready), 64'd0);
    step();
    check_wb("full_x10", 5'd10, 32'h100A);
    #1 check("full_d_lsu_ready", 64'(lsu_ready), 64'd1);
    step();
    check_wb("full_x3", 5'd3, 32'h2003);
    set_lsu(1'b0, 5'd0, 32'h0);
    set_exe(1'b1, 5'd4, 32'h2004);
    #1 check("full_e_exe_ready", 64'(exe_ready), 64'd0);
    step();
    check_wb("full_x11", 5'd11, 32'h100B);
    step();
    check_wb("full_x4", 5'd4, 32'h2004);
    set_exe(1'b0, 5'd0, 32'h0);
    step();
    check_wb("full_x12", 5'd12, 32'h100C);
    check("full_count", 64'(dut.count), 64'd0);

    // EXE rd=0: slot consumed, no write, outputs hold
    set_exe(1'b1, 5'd0, 32'hFF);
    #1 check("rd0_ready", 64'(exe_ready), 64'd1);
    step();
    set_exe(1'b0, 5'd0, 32'h0);
    check("rd0_en", 64'(rd_final_rd_wb_en), 64'd0);
    check("rd0_hold_rd", 64'(rd_final_rd_wb), 64'd12);
    check("rd0_hold_data", 64'(rd_final_rd_wb_data), 64'h100C);

    // LSU with rd_en=0 is discarded
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_rd_en = 1'b0; lsu_data = 32'h55;
    step();
    set_lsu(1'b0, 5'd0, 32'h0);
    check("lsu_noen_en", 64'(rd_final_rd_wb_en), 64'd0);
    check("lsu_noen_count", 64'(dut.count), 64'd0);

    // Reset with count=2
    set_exe(1'b1, 5'd5, 32'h2005);
    set_lsu(1'b1, 5'd13, 32'h100D);
    step();
    set_exe(1'b1, 5'd6, 32'h2006);
    set_lsu(1'b1, 5'd14, 32'h100E);
    step();
    set_exe(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    check("pre_rst_count", 64'(dut.count), 64'd2);
    check_wb("pre_rst_x6", 5'd6, 32'h2006);
    reset = 1'b0;
    #1;
    check("mid_rst_en", 64'(rd_final_rd_wb_en), 64'd0);
    check("mid_rst_rd", 64'(rd_final_rd_wb), 64'd0);
    check("mid_rst_data", 64'(rd_final_rd_wb_data), 64'd0);
    check("mid_rst_count", 64'(dut.count), 64'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_en", 64'(rd_final_rd_wb_en), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
